clock_divider_prog: RTL and testbench

- Multi-channel programmable clock divider. Generalises the fixed single-output toggle divider to N independent channels.
- Each channel has a runtime-loadable terminal count, and a selectable mode: square-wave toggle or single-cycle tick.
- Sits between the board oscillator and slow consumers such as display multiplexing, debouncers and blinkers.
- Outputs are registered, clock-domain-local enables or derived clocks.

---
 rtl/clock_divider_prog.sv | 59 +++++
 tb/tb_clock_divider_prog.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider: each channel has a runtime-loadable
// terminal count and a toggle (square wave) or pulse (single-cycle) output mode.
module clock_divider_prog #(
   parameter int              CHANNELS      = 2,
   parameter int              SIZE          = 16,
   parameter logic [SIZE-1:0] DEFAULT_LIMIT = 16'd50000,
   parameter logic            DEFAULT_MODE  = 1'b0
) (
   input  logic                     clk_in,
   input  logic                     rst,
   input  logic                     en,
   input  logic [CHANNELS-1:0]      load,
   input  logic [CHANNELS*SIZE-1:0] limit_in,
   input  logic [CHANNELS-1:0]      mode_in,
   output logic [CHANNELS-1:0]      clk_out,
   output logic [CHANNELS-1:0]      tick
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [SIZE-1:0] count;
      logic [SIZE-1:0] limit_q;
      logic            mode_q;
      logic            clk_q;
      logic            tick_q;

      // Load has priority over the enable and the terminal count, so a reload
      // always restarts the channel from a clean phase with outputs low.
      always_ff @(posedge clk_in) begin
         if (rst) begin
            count   <= '0;
            limit_q <= DEFAULT_LIMIT;
            mode_q  <= DEFAULT_MODE;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
         end else if (load[g]) begin
            count   <= '0;
            limit_q <= limit_in[g*SIZE +: SIZE];
            mode_q  <= mode_in[g];
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
         end else if (!en) begin
            tick_q <= 1'b0;
            if (mode_q) clk_q <= 1'b0;
         end else if (count == limit_q) begin
            count  <= '0;
            tick_q <= 1'b1;
            clk_q  <= mode_q ? 1'b1 : ~clk_q;
         end else begin
            count  <= count + SIZE'(1);
            tick_q <= 1'b0;
            if (mode_q) clk_q <= 1'b0;
         end
      end

      assign clk_out[g] = clk_q;
      assign tick[g]    = tick_q;
   end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: constant vector table, directed
// corner sequences and randomized stimulus against an elapsed-cycle model.
module tb_clock_divider_prog;
   localparam int CH = 2;
   localparam int SZ = 16;

   logic              clk_in = 1'b0;
   logic              rst;
   logic              en;
   logic [CH-1:0]     load;
   logic [CH*SZ-1:0]  limit_in;
   logic [CH-1:0]     mode_in;
   logic [CH-1:0]     clk_out;
   logic [CH-1:0]     tick;

   clock_divider_prog #(
      .CHANNELS(CH),
      .SIZE(SZ),
      .DEFAULT_LIMIT(16'd50000),
      .DEFAULT_MODE(1'b0)
   ) dut (
      .clk_in(clk_in),
      .rst(rst),
      .en(en),
      .load(load),
      .limit_in(limit_in),
      .mode_in(mode_in),
      .clk_out(clk_out),
      .tick(tick)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: per channel, enabled edges since the last load/reset. Tick when that
   // number is a multiple of (limit+1); toggle output is the parity of ticks seen.
   longint el  [CH];
   longint lim [CH];
   bit     md  [CH];
   bit     e_tick [CH];
   bit     e_clk  [CH];

   typedef struct {
      logic        en;
      logic [1:0]  load;
      logic [15:0] l0;
      logic        m0;
      logic        x_tick;
      logic        x_clk;
   } vec_t;
   vec_t tv [20];

   task automatic chk1(input string nm, input int c, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s ch%0d: got %b, expected %b at %0t", nm, c, act, exp, $time);
      end
   endtask

   task automatic chkn(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < CH; c++) begin
         if (rst) begin
            el[c] = 0; lim[c] = 50000; md[c] = 1'b0; e_tick[c] = 1'b0; e_clk[c] = 1'b0;
         end else if (load[c]) begin
            lim[c] = longint'(limit_in[c*SZ +: SZ]);
            md[c]  = mode_in[c];
            el[c]  = 0; e_tick[c] = 1'b0; e_clk[c] = 1'b0;
         end else if (!en) begin
            e_tick[c] = 1'b0;
            if (md[c]) e_clk[c] = 1'b0;
         end else begin
            el[c]++;
            e_tick[c] = ((el[c] % (lim[c] + 1)) == 0);
            e_clk[c]  = md[c] ? e_tick[c] : (((el[c] / (lim[c] + 1)) % 2) == 1);
         end
      end
   endtask

   task automatic step(input string nm);
      @(posedge clk_in);
      model_edge();
      #1;
      for (int c = 0; c < CH; c++) begin
         chk1({nm, "_clk"}, c, clk_out[c], e_clk[c]);
         chk1({nm, "_tick"}, c, tick[c], e_tick[c]);
      end
   endtask

   initial begin
      longint first0, first1, nt0, nt1;

      tv[0]  = '{1'b1, 2'b01, 16'd3, 1'b0, 1'b0, 1'b0};
      tv[1]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[2]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[3]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[4]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b1, 1'b1};
      tv[5]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1};
      tv[6]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1};
      tv[7]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1};
      tv[8]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b1, 1'b0};
      tv[9]  = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[10] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[11] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[12] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b1, 1'b1};
      tv[13] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1};
      tv[14] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1};
      tv[15] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b1};
      tv[16] = '{1'b1, 2'b01, 16'd2, 1'b0, 1'b0, 1'b0};
      tv[17] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[18] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b0, 1'b0};
      tv[19] = '{1'b1, 2'b00, 16'd0, 1'b0, 1'b1, 1'b1};

      rst = 1'b1; en = 1'b1; load = 2'b11; limit_in = '0; mode_in = 2'b11;
      for (int k = 0; k < 2; k++) begin
         step("reset");
         chk1("reset_clk_out", 0, (clk_out == 2'b00), 1'b1);
         chk1("reset_tick", 0, (tick == 2'b00), 1'b1);
      end

      // Release with ch0 on its default limit while ch1 runs the all-ones limit.
      rst = 1'b0; load = 2'b10; limit_in = {16'hFFFF, 16'h0000}; mode_in = 2'b00;
      first0 = -1; first1 = -1; nt0 = 0; nt1 = 0;
      for (int k = 1; k <= 65537; k++) begin
         step("long");
         load = 2'b00;
         if (tick[0]) begin nt0++; if (first0 < 0) first0 = k; end
         if (tick[1]) begin nt1++; if (first1 < 0) first1 = k; end
      end
      chkn("default_first_tick", first0, 50001);
      chkn("default_tick_count", nt0, 1);
      chkn("maxlim_first_tick", first1, 65537);
      chkn("maxlim_tick_count", nt1, 1);

      for (int i = 0; i < 20; i++) begin
         en = tv[i].en; load = tv[i].load; limit_in[15:0] = tv[i].l0; mode_in[0] = tv[i].m0;
         step("tbl");
         chk1($sformatf("tbl%0d_tick", i), 0, tick[0], tv[i].x_tick);
         chk1($sformatf("tbl%0d_clk", i), 0, clk_out[0], tv[i].x_clk);
      end
      load = 2'b00;

      en = 1'b1; load = 2'b11; limit_in = {16'd1, 16'd4}; mode_in = 2'b01;
      step("indep_load");
      load = 2'b00;
      for (int k = 1; k <= 20; k++) begin
         step("indep");
         chk1("pulse_clk", 0, clk_out[0], (k % 5) == 0);
         chk1("indep_clk", 1, clk_out[1], ((k / 2) % 2) == 1);
         chk1("indep_tick", 1, tick[1], (k % 2) == 0);
      end

      load = 2'b01; limit_in[15:0] = 16'd5; mode_in = 2'b00;
      step("frz_load");
      load = 2'b00;
      for (int k = 0; k < 3; k++) step("frz_pre");
      en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step("frz_hold");
         chk1("frz_tick", 0, tick[0], 1'b0);
         chk1("frz_clk", 0, clk_out[0], 1'b0);
      end
      en = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         step("frz_resume");
         chk1("frz_resume_tick", 0, tick[0], e == 3);
         chk1("frz_resume_clk", 0, clk_out[0], e == 3);
      end

      load = 2'b01; limit_in[15:0] = 16'd0; mode_in = 2'b00;
      step("lim0_load");
      load = 2'b00;
      for (int k = 1; k <= 6; k++) begin
         step("lim0");
         chk1("lim0_tick", 0, tick[0], 1'b1);
         chk1("lim0_clk", 0, clk_out[0], (k % 2) == 1);
      end
      load = 2'b01; mode_in = 2'b01;
      step("lim0p_load");
      load = 2'b00;
      for (int k = 0; k < 4; k++) begin
         step("lim0p");
         chk1("lim0_pulse_clk", 0, clk_out[0], 1'b1);
      end
      en = 1'b0;
      step("lim0p_off");
      chk1("lim0_pulse_off_clk", 0, clk_out[0], 1'b0);
      chk1("lim0_pulse_off_tick", 0, tick[0], 1'b0);

      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(63) == 0);
         en  = ($urandom_range(3) != 0);
         for (int c = 0; c < CH; c++) begin
            load[c]               = ($urandom_range(15) == 0);
            limit_in[c*SZ +: SZ]  = 16'($urandom_range(7));
            mode_in[c]            = 1'($urandom_range(1));
         end
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
